// File: rtl/clkfwd_ctrl.sv
// clkfwd_ctrl -- start/stop sequencer for a forwarded (off-chip) clock.
//
// The block produces the D0/D1 data pair for the DDR output cell that drives
// the forwarded clock pin. The pin parks low while idle. After a start request
// it clocks through a warm-up of PRECYC periods and then runs. After a stop
// request it finishes the current period, issues POSTCYC more periods, and
// then parks low again.
//
// Parameters:
//   DIV      half-period in clk cycles; 1 = full rate, >=2 = clk/(2*DIV)
//   PRECYC   forwarded periods before fwd_rdy asserts (0..255)
//   POSTCYC  extra forwarded periods after the current one on stop (0..255)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active high
//   start_req  in   one-cycle start request (ignored outside IDLE)
//   stop_req   in   one-cycle stop request (ignored in IDLE/DRAIN, wins over start)
//   fwd_d0     out  DDR cell data for rising edge of clk
//   fwd_d1     out  DDR cell data for falling edge of clk
//   fwd_rdy    out  forwarded clock stable (RUN only)
//   busy       out  sequencer not idle
//   done       out  one-cycle pulse: drain complete, pin parked low
module clkfwd_ctrl #(
    parameter int unsigned DIV     = 1,
    parameter int unsigned PRECYC  = 4,
    parameter int unsigned POSTCYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start_req,
    input  logic stop_req,
    output logic fwd_d0,
    output logic fwd_d1,
    output logic fwd_rdy,
    output logic busy,
    output logic done
);

    localparam int unsigned   HW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [HW-1:0] HCNT_LAST = HW'(DIV - 1);
    localparam logic [7:0]    PRE_LAST  = (PRECYC > 0) ? 8'(PRECYC - 1) : 8'd0;
    localparam logic [7:0]    POST_LAST = 8'(POSTCYC);

    typedef enum logic [1:0] {
        IDLE,
        WARM,
        RUN,
        DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_phase;
    logic            w_phase_nxt;
    logic [HW-1:0]   r_hcnt;
    logic [HW-1:0]   w_hcnt_nxt;
    logic [7:0]      r_pcnt;
    logic [7:0]      w_pcnt_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_period_end;

    // Last cycle of a forwarded period: at full rate every active cycle,
    // otherwise the final cycle of the low half.
    always_comb begin
        w_period_end = 1'b0;
        if (r_state != IDLE) begin
            if (DIV == 1) begin
                w_period_end = 1'b1;
            end else begin
                w_period_end = !r_phase && (r_hcnt == HCNT_LAST);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_req && !stop_req) begin
                    if (PRECYC > 0) begin
                        w_state_nxt = WARM;
                        w_pcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            WARM: begin
                if (stop_req) begin
                    w_state_nxt = DRAIN;
                    w_pcnt_nxt  = '0;
                end else if (w_period_end) begin
                    w_pcnt_nxt = r_pcnt + 8'd1;
                    if (r_pcnt == PRE_LAST) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (stop_req) begin
                    w_state_nxt = DRAIN;
                    w_pcnt_nxt  = '0;
                end
            end
            DRAIN: begin
                if (w_period_end) begin
                    if (r_pcnt == POST_LAST) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_pcnt_nxt = r_pcnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Divider: held at phase=1/hcnt=0 in IDLE and on the way into IDLE, so
    // every start begins with a full high half.
    always_comb begin
        w_phase_nxt = r_phase;
        w_hcnt_nxt  = r_hcnt;
        if (r_state == IDLE || w_state_nxt == IDLE) begin
            w_phase_nxt = 1'b1;
            w_hcnt_nxt  = '0;
        end else if (DIV > 1) begin
            if (r_hcnt == HCNT_LAST) begin
                w_hcnt_nxt  = '0;
                w_phase_nxt = !r_phase;
            end else begin
                w_hcnt_nxt = r_hcnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= 1'b1;
            r_hcnt  <= '0;
            r_pcnt  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        fwd_d0 = 1'b0;
        fwd_d1 = 1'b0;
        if (r_state != IDLE) begin
            if (DIV == 1) begin
                fwd_d0 = 1'b1;
                fwd_d1 = 1'b0;
            end else begin
                fwd_d0 = r_phase;
                fwd_d1 = r_phase;
            end
        end
        fwd_rdy = (r_state == RUN);
        busy    = (r_state != IDLE);
        done    = r_done;
    end

endmodule

// File: tb/tb_clkfwd_ctrl.sv
// tb_clkfwd_ctrl -- self-checking bench for clkfwd_ctrl.
//
// Four instances with different DIV/PRECYC/POSTCYC share one set of inputs.
// Each is compared every cycle against a timeline model: cycles since start,
// period index = t / period length, drain end computed arithmetically from
// the cycle at which stop took effect.
module tb_clkfwd_ctrl;

    localparam int NCFG = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_req = 1'b0;
    logic stop_req = 1'b0;

    logic [NCFG-1:0] d0, d1, rdy, bsy, dn;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_act  [NCFG];
    bit          m_stop [NCFG];
    bit          m_done [NCFG];
    int unsigned m_t    [NCFG];
    int unsigned m_end  [NCFG];

    logic s_r, s_st, s_sp;

    always #5 clk = ~clk;

    clkfwd_ctrl #(.DIV(1), .PRECYC(4), .POSTCYC(2)) u_a (
        .clk(clk), .rst(rst), .start_req(start_req), .stop_req(stop_req),
        .fwd_d0(d0[0]), .fwd_d1(d1[0]), .fwd_rdy(rdy[0]), .busy(bsy[0]), .done(dn[0]));
    clkfwd_ctrl #(.DIV(3), .PRECYC(2), .POSTCYC(0)) u_b (
        .clk(clk), .rst(rst), .start_req(start_req), .stop_req(stop_req),
        .fwd_d0(d0[1]), .fwd_d1(d1[1]), .fwd_rdy(rdy[1]), .busy(bsy[1]), .done(dn[1]));
    clkfwd_ctrl #(.DIV(1), .PRECYC(0), .POSTCYC(2)) u_c (
        .clk(clk), .rst(rst), .start_req(start_req), .stop_req(stop_req),
        .fwd_d0(d0[2]), .fwd_d1(d1[2]), .fwd_rdy(rdy[2]), .busy(bsy[2]), .done(dn[2]));
    clkfwd_ctrl #(.DIV(2), .PRECYC(1), .POSTCYC(3)) u_d (
        .clk(clk), .rst(rst), .start_req(start_req), .stop_req(stop_req),
        .fwd_d0(d0[3]), .fwd_d1(d1[3]), .fwd_rdy(rdy[3]), .busy(bsy[3]), .done(dn[3]));

    function automatic int unsigned cdiv(input int i);
        case (i)
            0: return 1;
            1: return 3;
            2: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int unsigned cpre(input int i);
        case (i)
            0: return 4;
            1: return 2;
            2: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned cpost(input int i);
        case (i)
            0: return 2;
            1: return 0;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    // Forwarded period length in clk cycles.
    function automatic int unsigned plen(input int i);
        return (cdiv(i) == 1) ? 1 : 2 * cdiv(i);
    endfunction

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cfg%0d @%0t: observed %b expected %b", tag, idx, $time, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic st, input logic sp);
        for (int i = 0; i < NCFG; i++) begin
            m_done[i] = 1'b0;
            if (r) begin
                m_act[i]  = 1'b0;
                m_stop[i] = 1'b0;
                m_t[i]    = 0;
            end else if (!m_act[i]) begin
                if (st && !sp) begin
                    m_act[i]  = 1'b1;
                    m_stop[i] = 1'b0;
                    m_t[i]    = 0;
                end
            end else begin
                m_t[i]++;
                if (m_stop[i]) begin
                    if (m_t[i] == m_end[i]) begin
                        m_act[i]  = 1'b0;
                        m_stop[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end else if (sp) begin
                    // First drain cycle is m_t; finish the period it lies in
                    // plus POSTCYC more, then go idle.
                    m_stop[i] = 1'b1;
                    m_end[i]  = (m_t[i] / plen(i) + cpost(i) + 1) * plen(i);
                end
            end
        end
    endtask

    task automatic check_all();
        logic e_d0, e_d1, e_rdy;
        for (int i = 0; i < NCFG; i++) begin
            e_d0  = 1'b0;
            e_d1  = 1'b0;
            e_rdy = 1'b0;
            if (m_act[i]) begin
                if (cdiv(i) == 1) begin
                    e_d0 = 1'b1;
                end else begin
                    e_d0 = ((m_t[i] % (2 * cdiv(i))) < cdiv(i));
                    e_d1 = e_d0;
                end
                e_rdy = !m_stop[i] && ((m_t[i] / plen(i)) >= cpre(i));
            end
            chk("fwd_d0", i, d0[i], e_d0);
            chk("fwd_d1", i, d1[i], e_d1);
            chk("fwd_rdy", i, rdy[i], e_rdy);
            chk("busy", i, bsy[i], m_act[i]);
            chk("done", i, dn[i], m_done[i]);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic sp);
        rst       = r;
        start_req = st;
        stop_req  = sp;
        @(posedge clk);
        #1;
        model_step(r, st, sp);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < NCFG; i++) begin
            m_act[i]  = 1'b0;
            m_stop[i] = 1'b0;
            m_done[i] = 1'b0;
            m_t[i]    = 0;
            m_end[i]  = 0;
        end

        // Reset state
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Start, warm-up, run, stop and drain
        step(1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0, 1'b0);

        // Simultaneous start+stop in IDLE, then lone stop in IDLE
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Stop during the second active cycle, then start during drain
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0, 1'b0);

        // Reset mid-run: parks immediately, no drain, no done
        step(1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            s_r  = ($urandom_range(0, 299) == 0);
            s_st = ($urandom_range(0, 7) == 0);
            s_sp = ($urandom_range(0, 11) == 0);
            step(s_r, s_st, s_sp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
